// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin data memory arbiter and access sequencer (optional DMEM_ARB_RMW_EN: byte-enable read-modify-write)
module dmem_arbiter #(
    parameter int WORD_SIZE     = 32,
    parameter int DATA_MEM_SIZE = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req,
    input  logic [1:0]           we,
    input  logic [WORD_SIZE-1:0] addr0,
    input  logic [WORD_SIZE-1:0] addr1,
    input  logic [WORD_SIZE-1:0] wdata0,
    input  logic [WORD_SIZE-1:0] wdata1,
    input  logic [3:0]           be0,
    input  logic [3:0]           be1,
    output logic [1:0]           gnt,
    output logic [1:0]           done,
    output logic                 err,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 mem_read_en,
    output logic                 mem_write_en,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    // Highest byte address at which a whole word still fits in the memory
    localparam logic [WORD_SIZE-1:0] MAX_ADDR = WORD_SIZE'(DATA_MEM_SIZE - 4);

`ifdef DMEM_ARB_RMW_EN
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif

    state_t                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   id_q, id_d;
    logic                   we_q, we_d;
    logic [WORD_SIZE-1:0]   addr_q, addr_d;
    logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
    logic                   err_q, err_d;
    logic [WORD_SIZE-1:0]   rdata_q, rdata_d;
    logic                   access_err;
    logic                   win;
    logic [1:0]             id_onehot;

`ifdef DMEM_ARB_RMW_EN
    logic [3:0]             be_q, be_d;
    logic [WORD_SIZE-1:0]   merged;

    // Lane-wise merge of new write data over the word captured in ACCESS
    always_comb begin
        merged = rdata_q;
        for (int k = 0; k < 4; k++) begin
            if (be_q[k]) merged[8*k +: 8] = wdata_q[8*k +: 8];
        end
    end

    // Byte-enable register, only meaningful for partial writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) be_q <= 4'h0;
        else      be_q <= be_d;
    end
`else
    logic unused_be;
    assign unused_be = ^{be0, be1};
`endif

    assign access_err = (addr_q[1:0] != 2'b00) || (addr_q > MAX_ADDR);
    assign id_onehot  = id_q ? 2'b10 : 2'b01;

    // State and transaction registers; async reset aborts any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    // Arbitration, access sequencing and output decode from registered state
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
`ifdef DMEM_ARB_RMW_EN
        be_d         = be_q;
`endif
        win          = 1'b0;
        gnt          = 2'b00;
        done         = 2'b00;
        err          = 1'b0;
        rdata        = '0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    win          = (req == 2'b11) ? ~last_grant_q : req[1];
                    id_d         = win;
                    last_grant_d = win;
                    we_d         = we[win];
                    addr_d       = win ? addr1 : addr0;
                    wdata_d      = win ? wdata1 : wdata0;
`ifdef DMEM_ARB_RMW_EN
                    be_d         = win ? be1 : be0;
`endif
                    err_d        = 1'b0;
                    rdata_d      = '0;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                gnt      = id_onehot;
                mem_addr = {addr_q[WORD_SIZE-1:2], 2'b00};
                state_d  = RESP;
                if (access_err) begin
                    err_d = 1'b1;
                end else if (!we_q) begin
                    mem_read_en = 1'b1;
                    rdata_d     = mem_rdata;
`ifdef DMEM_ARB_RMW_EN
                end else if (be_q != 4'hF) begin
                    mem_read_en = 1'b1;
                    rdata_d     = mem_rdata;
                    state_d     = MERGE;
`endif
                end else begin
                    mem_write_en = 1'b1;
                    mem_wdata    = wdata_q;
                end
            end
`ifdef DMEM_ARB_RMW_EN
            MERGE: begin
                mem_addr = {addr_q[WORD_SIZE-1:2], 2'b00};
                if (be_q != 4'h0) begin
                    mem_write_en = 1'b1;
                    mem_wdata    = merged;
                end
                state_d = RESP;
            end
`endif
            RESP: begin
                done    = id_onehot;
                err     = err_q;
                rdata   = (we_q || err_q) ? '0 : rdata_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a behavioural word memory
`timescale 1ns/1ps
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req, we;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [3:0]  be0, be1;
    logic [1:0]  gnt, done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_read_en, mem_write_en;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(.WORD_SIZE(32), .DATA_MEM_SIZE(1024)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .be0(be0), .be1(be1), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [31:0] mem [256];
    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;
    logic        wr_commit;
    logic [31:0] wr_c_addr, wr_c_data;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        wr_commit <= 1'b0;
        if (pre_en) begin
            mem[pre_idx] <= pre_val;
        end else if (mem_write_en) begin
            mem[mem_addr[9:2]] <= mem_wdata;
            wr_commit <= 1'b1;
            wr_c_addr <= mem_addr;
            wr_c_data <= mem_wdata;
        end
    end

    typedef struct { int port; logic e; logic [31:0] rd; } resp_t;
    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    resp_t resp_q[$];
    wr_t   wr_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        resp_t r;
        if (rst && done != 2'b00) begin
            if (resp_q.size() == 0) begin
                check("unexpected_done", 128'(done), 128'(0));
            end else begin
                r = resp_q.pop_front();
                check("done_port", 128'(done), 128'(2'b01 << r.port));
                check("done_err", 128'(err), 128'(r.e));
                check("done_rdata", 128'(rdata), 128'(r.rd));
            end
        end
    end

    always @(negedge clk) begin
        wr_t w;
        if (wr_commit) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write", {wr_c_addr, wr_c_data}, 128'(0));
            end else begin
                w = wr_q.pop_front();
                check("mem_write", {wr_c_addr, wr_c_data}, {w.a, w.d});
            end
        end
    end

    task automatic mem_set(input logic [7:0] idx, input logic [31:0] val);
        @(posedge clk); #1;
        pre_idx = idx; pre_val = val; pre_en = 1'b1;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic single(input int p, input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] b, input logic e, input logic [31:0] rd, input int done_lat,
                          input logic exp_strobe, input logic wr_exp, input logic [31:0] wr_data,
                          input string tag);
        int n, g_at, d_at, strobes;
        resp_q.push_back('{p, e, rd});
        if (wr_exp) wr_q.push_back('{{a[31:2], 2'b00}, wr_data});
        @(posedge clk); #1;
        if (p == 0) begin addr0 = a; wdata0 = wd; be0 = b; end
        else        begin addr1 = a; wdata1 = wd; be1 = b; end
        we[p] = w; req[p] = 1'b1;
        n = 0; g_at = -1; d_at = -1; strobes = 0;
        while (d_at < 0 && n < 20) begin
            @(negedge clk); n++;
            if (mem_read_en || mem_write_en) strobes++;
            if (gnt[p] && g_at < 0) begin g_at = n - 1; req[p] = 1'b0; end
            if (done[p]) d_at = n - 1;
        end
        req[p] = 1'b0;
        check({tag, "_gnt_cycle"}, 128'(g_at), 128'(1));
        check({tag, "_done_cycle"}, 128'(d_at), 128'(done_lat));
        check({tag, "_strobe_seen"}, 128'(strobes != 0), 128'(exp_strobe));
    endtask

    task automatic dual(input int rem0, input int rem1, input int first, input string tag);
        int rem[2];
        int exp_p, n, p;
        rem[0] = rem0; rem[1] = rem1; exp_p = first; n = 0;
        @(posedge clk); #1;
        req = 2'b11;
        while ((rem[0] + rem[1]) > 0 && n < 60) begin
            @(negedge clk); n++;
            if (gnt != 2'b00) begin
                check({tag, "_grant_order"}, 128'(gnt), 128'(2'b01 << exp_p));
                p = gnt[1] ? 1 : 0;
                rem[p]--;
                if (rem[p] <= 0) req[p] = 1'b0;
                exp_p = 1 - exp_p;
            end
        end
        req = 2'b00;
        check({tag, "_all_granted"}, 128'(rem[0] + rem[1]), 128'(0));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        logic [31:0] rmw_exp;
        rst = 1'b0; req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; be0 = 4'hF; be1 = 4'hF;
        pre_en = 1'b0; pre_idx = '0; pre_val = '0;

        repeat (2) @(negedge clk);
        check("reset_outputs",
              {gnt, done, err, rdata, mem_read_en, mem_write_en, mem_addr, mem_wdata}, 128'(0));
        rst = 1'b1;

        mem_set(8'd4, 32'hDEADBEEF);
        mem_set(8'd0, 32'h0BADF00D);
        mem_set(8'd1, 32'h55AA55AA);
        mem_set(8'd2, 32'h12345678);
        mem_set(8'd3, 32'hAABBCCDD);

        single(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, 2, 1'b1, 1'b0, 32'h0, "rd0");
        single(1, 1'b0, 32'h6, 32'h0, 4'hF, 1'b1, 32'h0, 2, 1'b0, 1'b0, 32'h0, "misaligned");
        single(1, 1'b0, 32'h400, 32'h0, 4'hF, 1'b1, 32'h0, 2, 1'b0, 1'b0, 32'h0, "out_of_range");

        // Both ports stream full-word writes; port 0 was not last granted so it goes first
        addr0 = 32'h0; wdata0 = 32'h11111111; be0 = 4'hF;
        addr1 = 32'h4; wdata1 = 32'h22222222; be1 = 4'hF;
        we = 2'b11;
        for (int i = 0; i < 2; i++) begin
            resp_q.push_back('{0, 1'b0, 32'h0});
            resp_q.push_back('{1, 1'b0, 32'h0});
            wr_q.push_back('{32'h0, 32'h11111111});
            wr_q.push_back('{32'h4, 32'h22222222});
        end
        dual(2, 2, 0, "stream_wr");

        // Reset lands during the ACCESS cycle of a port 0 write
        @(posedge clk); #1;
        addr0 = 32'h8; wdata0 = 32'hCAFEF00D; be0 = 4'hF; we[0] = 1'b1; req[0] = 1'b1;
        n = 0;
        while (!gnt[0] && n < 10) begin @(negedge clk); n++; end
        check("rst_test_gnt_seen", 128'(gnt[0]), 128'(1));
        rst = 1'b0; #1;
        check("rst_async_outputs",
              {gnt, done, err, rdata, mem_read_en, mem_write_en, mem_addr, mem_wdata}, 128'(0));
        req[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mem_unchanged", 128'(mem[2]), 128'(32'h12345678));

        // Tie after reset must favour port 0 even though port 0 was granted last
        addr0 = 32'h0; addr1 = 32'h4; we = 2'b00;
        resp_q.push_back('{0, 1'b0, 32'h11111111});
        resp_q.push_back('{1, 1'b0, 32'h22222222});
        dual(1, 1, 0, "post_rst_tie");

`ifdef DMEM_ARB_RMW_EN
        rmw_exp = 32'hAA22CC44;
        single(0, 1'b1, 32'hC, 32'h11223344, 4'b0101, 1'b0, 32'h0, 3, 1'b1, 1'b1, rmw_exp, "part_write");
`else
        rmw_exp = 32'h11223344;
        single(0, 1'b1, 32'hC, 32'h11223344, 4'b0101, 1'b0, 32'h0, 2, 1'b1, 1'b1, rmw_exp, "part_write");
`endif
        repeat (2) @(negedge clk);
        check("part_write_mem", 128'(mem[3]), 128'(rmw_exp));
        check("stream_mem0", 128'(mem[0]), 128'(32'h11111111));
        check("resp_queue_empty", 128'(resp_q.size()), 128'(0));
        check("write_queue_empty", 128'(wr_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and access sequencer in front of the byte-addressed data memory (32-bit word, 4 byte cells per word, big-endian packing).
- Port 0 is the CPU load/store stage; port 1 is a secondary master (DMA/debug loader).
- Accepts one request at a time and drives the memory's read/write strobes, address and write data.
- Returns read data with a fixed latency and flags misaligned or out-of-range accesses instead of issuing them.

Parameters:
- WORD_SIZE, 32, data/address width (matches `WORD_SIZE).
- DATA_MEM_SIZE, 1024, memory size in bytes; the legal address range is 0 .. DATA_MEM_SIZE-1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-low.
- req  input  2  request per port; held high until gnt for that port.
- we  input  2  per-port write (1) / read (0); sampled with req.
- addr0, addr1  input  WORD_SIZE  per-port byte address.
- wdata0, wdata1  input  WORD_SIZE  per-port write data.
- be0, be1  input  4  per-port byte enables; be[k] covers data[8k+7:8k]. Used only with DMEM_ARB_RMW_EN.
- gnt  output  2  one-cycle acceptance pulse per port.
- done  output  2  one-cycle completion pulse per port.
- err  output  1  valid with done: the access was rejected.
- rdata  output  WORD_SIZE  read data; valid with done.
- mem_read_en  output  1  memory read strobe.
- mem_write_en  output  1  memory write strobe.
- mem_addr  output  WORD_SIZE  memory address, word-aligned.
- mem_wdata  output  WORD_SIZE  memory write data.
- mem_rdata  input  WORD_SIZE  memory read data; combinational from mem_addr.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, last_grant=1 (so port 0 wins the first tie). gnt, done, err, rdata, mem_read_en, mem_write_en, mem_addr and mem_wdata are all 0.
- Reset asserted mid-operation aborts the transaction. No done is issued and no memory write is issued after reset assertion.
- State IDLE:
  - No requests: stay in IDLE.
  - One port requesting: that port wins.
  - Both ports requesting: the port != last_grant wins (round robin).
  - On the clock edge, latch the winner's id, we, addr, wdata and be; update last_grant; go to ACCESS.
- State ACCESS (one cycle):
  - gnt[id]=1.
  - mem_addr = {addr[WORD_SIZE-1:2], 2'b00}.
  - Error check: if addr[1:0]!=0 or addr > DATA_MEM_SIZE-4, no strobe is asserted and the state goes to RESP with err pending.
  - Read: mem_read_en=1; mem_rdata is captured into rdata at the end of the cycle.
  - Write: mem_write_en=1, mem_wdata=wdata.
  - Go to RESP.
- State RESP (one cycle):
  - done[id]=1, with err and rdata valid.
  - rdata=0 for writes and for errors.
  - Go to IDLE.
- Latency: req seen in IDLE at cycle N -> gnt in cycle N+1 -> done in cycle N+2. Maximum throughput is one access per 3 cycles.
- Outputs are registered or decoded from registered state only; there is no combinational path from req to gnt.
- gnt and done are never asserted for both ports in the same cycle.
- Memory strobes are 0 in IDLE and RESP.
- A req deasserted before gnt is illegal; behaviour is unspecified.

Optional Feature:
- Macro: DMEM_ARB_RMW_EN.
- With the macro defined, a write with be != 4'hF is a read-modify-write:
  - ACCESS: mem_read_en=1; mem_rdata is captured.
  - MERGE: mem_write_en=1; mem_wdata lane k = be[k] ? wdata lane k : captured lane k.
  - Then RESP. gnt is pulsed in ACCESS; done follows 3 cycles after IDLE.
  - be=4'h0: no memory write; done with err=0.
  - Full-word writes keep the 3-cycle path.
- Without the macro: be inputs are ignored, the MERGE state does not exist, and every write is a full word.

Test Plan:
- Reset, then a port 0 read at addr 0x10 with memory holding 0xDEADBEEF -> gnt[0] in cycle 1, done[0] in cycle 2, rdata=0xDEADBEEF, err=0.
- Both ports request writes continuously (port 0 wdata 0x11111111 @0x0, port 1 wdata 0x22222222 @0x4) -> grant order 0,1,0,1 and each write appears once per grant on mem_write_en.
- Port 1 read at addr 0x6 (misaligned), then at addr 0x400 (out of range) -> no strobes, done[1] with err=1 and rdata=0 both times.
- Assert rst low during the ACCESS of a write -> all outputs go to 0 immediately, memory is unchanged, no done is issued, and the next request is served normally with port 0 favoured.
- With DMEM_ARB_RMW_EN: word holds 0xAABBCCDD, write be=4'b0101 with wdata 0x11223344 -> memory becomes 0xAA22CC44, done in cycle 3.
- Without DMEM_ARB_RMW_EN: the same stimulus writes 0x11223344 and done arrives in cycle 2.
